control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 178 +++++++++++++++++
 tb/tb_control_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit
//   Multi-cycle control FSM for a small accumulator-less datapath with an
//   instruction register, register file, ALU and data memory. Each
//   instruction is fetched, decoded, then executed in one or two cycles.
//   All control outputs are Moore-style: they depend only on the current
//   state, plus instruction-register fields routed out as addresses.
//
// Parameters
//   IW    instruction width; opcode is i_ir[IW-1:IW-4]
//   N_OP  number of ALU operations; o_aluS0 is clog2(N_OP) bits wide
//
// Ports
//   i_clk        clock, all state updates on the rising edge
//   i_rst_n      asynchronous active-low reset, forces INIT
//   i_ir         current instruction held by the instruction register
//   o_pcClr      clear program counter
//   o_pcUp       increment program counter
//   o_irLd       load instruction register from instruction memory
//   o_dAddr      data memory address
//   o_dWr        data memory write enable
//   o_rfS        register-file write mux (1 = data memory, 0 = ALU)
//   o_rfWAddr    register-file write address
//   o_rfWEn      register-file write enable
//   o_rfRaAddr   register-file read port A address
//   o_rfRbAddr   register-file read port B address
//   o_aluS0      ALU select (0 zero, 1 A+B, 2 A-B, 3 pass A)
//   o_outState   current state encoding for debug
module control_unit #(
  parameter int IW   = 16,
  parameter int N_OP = 8,
  localparam int AW  = (N_OP > 1) ? $clog2(N_OP) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [IW-1:0] i_ir,
  output logic          o_pcClr,
  output logic          o_pcUp,
  output logic          o_irLd,
  output logic [7:0]    o_dAddr,
  output logic          o_dWr,
  output logic          o_rfS,
  output logic [3:0]    o_rfWAddr,
  output logic          o_rfWEn,
  output logic [3:0]    o_rfRaAddr,
  output logic [3:0]    o_rfRbAddr,
  output logic [AW-1:0] o_aluS0,
  output logic [3:0]    o_outState
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_LOAD  = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_HALT  = 4'b0101;

  localparam logic [AW-1:0] ALU_ADD = AW'(1);
  localparam logic [AW-1:0] ALU_SUB = AW'(2);

  state_t     r_state;
  state_t     w_nextState;
  logic [3:0] w_opcode;

  assign w_opcode   = i_ir[IW-1:IW-4];
  assign o_outState = r_state;

  // State register. Reset is asynchronous so a pending memory or register
  // write is dropped the instant i_rst_n falls, without waiting for a clock.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_INIT;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. The opcode is only looked at in DECODE, so the
  // instruction register may change freely in every other state. HALT
  // has no way out except reset.
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_INIT:   w_nextState = S_FETCH;
      S_FETCH:  w_nextState = S_DECODE;
      S_DECODE: begin
        case (w_opcode)
          OP_NOOP:  w_nextState = S_NOOP;
          OP_STORE: w_nextState = S_STORE;
          OP_LOAD:  w_nextState = S_LOAD_A;
          OP_ADD:   w_nextState = S_ADD;
          OP_SUB:   w_nextState = S_SUB;
          OP_HALT:  w_nextState = S_HALT;
          default:  w_nextState = S_NOOP;
        endcase
      end
      S_LOAD_A: w_nextState = S_LOAD_B;
      S_NOOP,
      S_LOAD_B,
      S_STORE,
      S_ADD,
      S_SUB:    w_nextState = S_FETCH;
      S_HALT:   w_nextState = S_HALT;
      default:  w_nextState = S_INIT;
    endcase
  end

  // Output decode. Everything defaults to zero; each state raises only the
  // strobes it needs. LOAD takes two cycles because the data memory has a
  // one-cycle read latency: LOAD_A presents the address, LOAD_B writes.
  always_comb begin
    o_pcClr    = 1'b0;
    o_pcUp     = 1'b0;
    o_irLd     = 1'b0;
    o_dAddr    = 8'h00;
    o_dWr      = 1'b0;
    o_rfS      = 1'b0;
    o_rfWAddr  = 4'h0;
    o_rfWEn    = 1'b0;
    o_rfRaAddr = 4'h0;
    o_rfRbAddr = 4'h0;
    o_aluS0    = '0;
    unique case (r_state)
      S_INIT: begin
        o_pcClr = 1'b1;
      end
      S_FETCH: begin
        o_irLd = 1'b1;
        o_pcUp = 1'b1;
      end
      S_LOAD_A: begin
        o_dAddr   = i_ir[11:4];
        o_rfS     = 1'b1;
        o_rfWAddr = i_ir[3:0];
      end
      S_LOAD_B: begin
        o_dAddr   = i_ir[11:4];
        o_rfS     = 1'b1;
        o_rfWAddr = i_ir[3:0];
        o_rfWEn   = 1'b1;
      end
      S_STORE: begin
        o_dAddr    = i_ir[7:0];
        o_dWr      = 1'b1;
        o_rfRaAddr = i_ir[11:8];
      end
      S_ADD: begin
        o_rfRaAddr = i_ir[11:8];
        o_rfRbAddr = i_ir[7:4];
        o_rfWAddr  = i_ir[3:0];
        o_rfWEn    = 1'b1;
        o_aluS0    = ALU_ADD;
      end
      S_SUB: begin
        o_rfRaAddr = i_ir[11:8];
        o_rfRbAddr = i_ir[7:4];
        o_rfWAddr  = i_ir[3:0];
        o_rfWEn    = 1'b1;
        o_aluS0    = ALU_SUB;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit
//   Self-checking bench for control_unit. A reference model predicts the
//   state sequence from the instruction semantics (a queue of execute
//   steps per opcode) and the expected outputs per step; a compare process
//   checks every output on each falling edge. Directed sequences with
//   literal expectations pin the model, then a randomized run with random
//   instructions and random asynchronous reset pulses follows.
module tb_control_unit;

  localparam int IW   = 16;
  localparam int N_OP = 8;
  localparam int AW   = 3;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [IW-1:0] ir    = '0;
  logic          pcClr, pcUp, irLd, dWr, rfS, rfWEn;
  logic [7:0]    dAddr;
  logic [3:0]    rfWAddr, rfRaAddr, rfRbAddr, outState;
  logic [AW-1:0] aluS0;

  int nChecks = 0;
  int nFails  = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  control_unit #(.IW(IW), .N_OP(N_OP)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_ir       (ir),
    .o_pcClr    (pcClr),
    .o_pcUp     (pcUp),
    .o_irLd     (irLd),
    .o_dAddr    (dAddr),
    .o_dWr      (dWr),
    .o_rfS      (rfS),
    .o_rfWAddr  (rfWAddr),
    .o_rfWEn    (rfWEn),
    .o_rfRaAddr (rfRaAddr),
    .o_rfRbAddr (rfRbAddr),
    .o_aluS0    (aluS0),
    .o_outState (outState)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [IW-1:0] value);
    ir = value;
  endtask

  // Reference model: state numbers follow the published encodings. After
  // decode, the instruction expands into a list of execute steps followed
  // by a return to fetch; HALT expands to a step that never ends.
  int mState = 0;
  int mPending[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mState = 0;
      mPending.delete();
    end else if (mState == 9) begin
      mState = 9;
    end else if (mState == 0) begin
      mState = 1;
    end else if (mState == 1) begin
      mState = 2;
    end else if (mState == 2) begin
      mPending.delete();
      case (ir[15:12])
        4'd1:    mPending.push_back(6);
        4'd2:    begin mPending.push_back(4); mPending.push_back(5); end
        4'd3:    mPending.push_back(7);
        4'd4:    mPending.push_back(8);
        4'd5:    mPending.push_back(9);
        default: mPending.push_back(3);
      endcase
      if (ir[15:12] != 4'd5) mPending.push_back(1);
      mState = mPending.pop_front();
    end else begin
      mState = (mPending.size() > 0) ? mPending.pop_front() : 1;
    end
  end

  typedef struct packed {
    logic       pcClr;
    logic       pcUp;
    logic       irLd;
    logic [7:0] dAddr;
    logic       dWr;
    logic       rfS;
    logic [3:0] wAddr;
    logic       wEn;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [2:0] alu;
  } exp_t;

  function automatic exp_t expOut(input int st, input logic [15:0] x);
    exp_t e;
    e = '0;
    case (st)
      0: e.pcClr = 1'b1;
      1: begin e.pcUp = 1'b1; e.irLd = 1'b1; end
      4, 5: begin
        e.dAddr = x[11:4];
        e.rfS   = 1'b1;
        e.wAddr = x[3:0];
        e.wEn   = (st == 5);
      end
      6: begin
        e.dAddr = x[7:0];
        e.dWr   = 1'b1;
        e.ra    = x[11:8];
      end
      7, 8: begin
        e.ra    = x[11:8];
        e.rb    = x[7:4];
        e.wAddr = x[3:0];
        e.wEn   = 1'b1;
        e.alu   = (st == 7) ? 3'd1 : 3'd2;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin : cmpBlk
    exp_t e;
    if (checkEn) begin
      e = expOut(mState, ir);
      checkOutput("cmp_outState", 32'(outState), 32'(mState));
      checkOutput("cmp_pcClr",    32'(pcClr),    32'(e.pcClr));
      checkOutput("cmp_pcUp",     32'(pcUp),     32'(e.pcUp));
      checkOutput("cmp_irLd",     32'(irLd),     32'(e.irLd));
      checkOutput("cmp_dAddr",    32'(dAddr),    32'(e.dAddr));
      checkOutput("cmp_dWr",      32'(dWr),      32'(e.dWr));
      checkOutput("cmp_rfS",      32'(rfS),      32'(e.rfS));
      checkOutput("cmp_rfWAddr",  32'(rfWAddr),  32'(e.wAddr));
      checkOutput("cmp_rfWEn",    32'(rfWEn),    32'(e.wEn));
      checkOutput("cmp_rfRaAddr", 32'(rfRaAddr), 32'(e.ra));
      checkOutput("cmp_rfRbAddr", 32'(rfRbAddr), 32'(e.rb));
      checkOutput("cmp_aluS0",    32'(aluS0),    32'(e.alu));
    end
  end

  // Assert reset mid-cycle, check the async reset outputs before any clock
  // edge, then release shortly after a falling edge so the next rising edge
  // is the first one out of reset.
  task automatic doReset;
    @(negedge clk);
    #2 rst_n = 1'b0;
    checkEn = 1'b1;
    #1;
    checkOutput("rst_outState", 32'(outState), 32'd0);
    checkOutput("rst_pcClr",    32'(pcClr),    32'd1);
    checkOutput("rst_pcUp",     32'(pcUp),     32'd0);
    checkOutput("rst_dWr",      32'(dWr),      32'd0);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic midCycleReset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    checkOutput({tag, "_outState"}, 32'(outState), 32'd0);
    checkOutput({tag, "_pcClr"},    32'(pcClr),    32'd1);
    checkOutput({tag, "_dWr"},      32'(dWr),      32'd0);
    checkOutput({tag, "_rfWEn"},    32'(rfWEn),    32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [15:0] randInstr();
    logic [15:0] r;
    r = 16'($urandom);
    if (r[15:12] == 4'd5 && $urandom_range(0, 7) != 0) r[15:12] = 4'd0;
    return r;
  endfunction

  initial begin
    int seq[6];
    int pcu[6];
    seq = '{1, 2, 3, 1, 2, 3};
    pcu = '{1, 0, 0, 1, 0, 0};

    // NOOP stream after reset release
    applyStimulus(16'h0000);
    doReset();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checkOutput("noop_state", 32'(outState), 32'(seq[k]));
      checkOutput("noop_pcUp",  32'(pcUp),     32'(pcu[k]));
    end

    // LOAD
    applyStimulus(16'h2A53);
    doReset();
    @(negedge clk); checkOutput("load_fetch", 32'(outState), 32'd1);
    @(negedge clk); checkOutput("load_decode", 32'(outState), 32'd2);
    @(negedge clk);
    checkOutput("loadA_state", 32'(outState), 32'd4);
    checkOutput("loadA_dAddr", 32'(dAddr),    32'hA5);
    checkOutput("loadA_wAddr", 32'(rfWAddr),  32'd3);
    checkOutput("loadA_rfS",   32'(rfS),      32'd1);
    checkOutput("loadA_wEn",   32'(rfWEn),    32'd0);
    @(negedge clk);
    checkOutput("loadB_state", 32'(outState), 32'd5);
    checkOutput("loadB_wEn",   32'(rfWEn),    32'd1);
    @(negedge clk); checkOutput("load_refetch", 32'(outState), 32'd1);

    // STORE
    applyStimulus(16'h1B2C);
    doReset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("store_state", 32'(outState), 32'd6);
    checkOutput("store_dAddr", 32'(dAddr),    32'h2C);
    checkOutput("store_ra",    32'(rfRaAddr), 32'hB);
    checkOutput("store_dWr",   32'(dWr),      32'd1);
    @(negedge clk);
    checkOutput("store_dWrOff", 32'(dWr),      32'd0);
    checkOutput("store_next",   32'(outState), 32'd1);

    // ADD then SUB
    applyStimulus(16'h3127);
    doReset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("add_state", 32'(outState), 32'd7);
    checkOutput("add_ra",    32'(rfRaAddr), 32'd1);
    checkOutput("add_rb",    32'(rfRbAddr), 32'd2);
    checkOutput("add_w",     32'(rfWAddr),  32'd7);
    checkOutput("add_alu",   32'(aluS0),    32'd1);
    checkOutput("add_wEn",   32'(rfWEn),    32'd1);
    #1 applyStimulus(16'h4127);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("sub_state", 32'(outState), 32'd8);
    checkOutput("sub_ra",    32'(rfRaAddr), 32'd1);
    checkOutput("sub_rb",    32'(rfRbAddr), 32'd2);
    checkOutput("sub_w",     32'(rfWAddr),  32'd7);
    checkOutput("sub_alu",   32'(aluS0),    32'd2);

    // HALT holds through IR changes; only reset leaves it
    applyStimulus(16'h5000);
    doReset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("halt_enter", 32'(outState), 32'd9);
    for (int k = 0; k < 20; k++) begin
      #1 applyStimulus(16'($urandom));
      @(negedge clk);
      checkOutput("halt_hold", 32'(outState), 32'd9);
    end
    midCycleReset("halt_rst");

    // Reset in the middle of STORE and of LOAD_A
    applyStimulus(16'h1B2C);
    doReset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_store_dWr", 32'(dWr), 32'd1);
    midCycleReset("abort_store");
    applyStimulus(16'h2A53);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort_loadA_state", 32'(outState), 32'd4);
    midCycleReset("abort_loadA");

    // Unknown opcode behaves as NOOP
    applyStimulus(16'hF000);
    doReset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("unk_state", 32'(outState), 32'(seq[k]));
    end

    // Randomized run with occasional asynchronous reset pulses
    applyStimulus(randInstr());
    doReset();
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      #1 applyStimulus(randInstr());
      if ($urandom_range(0, 39) == 0) midCycleReset("rnd_rst");
    end

    @(negedge clk);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
